// File: rtl/dac_pkg.sv
// Shared definitions for the DAC write sequencer: state encoding,
// default phase widths and the data-bus width.
package dac_pkg;

  localparam int DAC_W = 8;

  localparam int SETUP_CYC_DEF = 2;
  localparam int WR_CYC_DEF    = 3;
  localparam int HOLD_CYC_DEF  = 2;
  localparam int LDAC_CYC_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    LOAD
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dac_write_seq.sv
// Parallel-bus write sequencer for the dual-channel DAC: takes a code over
// valid/ready and plays out csn/wrn/ldacn with programmable phase widths.
module dac_write_seq
  import dac_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int WR_CYC    = WR_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int LDAC_CYC  = LDAC_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DAC_W-1:0] in_code,
  input  logic             in_sel,
  input  logic             in_defer,
  input  logic             ld_req,
  output logic             busy,
  output logic             done,
  output logic             dac_csn,
  output logic             dac_wrn,
  output logic             dac_ldacn,
  output logic             dac_a_b,
  output logic [DAC_W-1:0] dac_d
);

  localparam int MAXP = max4(SETUP_CYC, WR_CYC, HOLD_CYC, LDAC_CYC);
  localparam int CW   = (MAXP < 1) ? 1 : $clog2(MAXP + 1);

  if (SETUP_CYC < 1 || WR_CYC < 1 || HOLD_CYC < 1 || LDAC_CYC < 1) begin : g_param_check
    $error("dac_write_seq: every phase width parameter must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             defer_q;
  logic             csn_q, wrn_q, ldacn_q, done_q, a_b_q;
  logic [DAC_W-1:0] d_q;
  logic             accept;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign accept   = (state_q == IDLE) && in_valid;

  // Counter is loaded with width-1 on each state entry and the phase ends when it reaches 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end else if (ld_req) begin
          state_d = LOAD;
          cnt_d   = CW'(LDAC_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = WRITE;
          cnt_d   = CW'(WR_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (defer_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = CW'(LDAC_CYC - 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they switch cleanly with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      defer_q <= 1'b0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      ldacn_q <= 1'b1;
      done_q  <= 1'b0;
      a_b_q   <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        d_q     <= in_code;
        a_b_q   <= in_sel;
        defer_q <= in_defer & ~ld_req;
      end
      csn_q   <= ~((state_d == SETUP) || (state_d == WRITE) || (state_d == HOLD));
      wrn_q   <= ~(state_d == WRITE);
      ldacn_q <= ~(state_d == LOAD);
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
    end
  end

  assign dac_csn   = csn_q;
  assign dac_wrn   = wrn_q;
  assign dac_ldacn = ldacn_q;
  assign done      = done_q;
  assign dac_a_b   = a_b_q;
  assign dac_d     = d_q;

endmodule

// File: tb/tb_dac_write_seq.sv
// Self-checking bench for dac_write_seq: cycle-exact strobe checks per scenario
// plus a scoreboard that matches every done pulse against the expected write.
module tb_dac_write_seq;
  import dac_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inValid = 1'b0;
  logic [7:0] inCode = 8'h00;
  logic       inSel = 1'b0;
  logic       inDefer = 1'b0;
  logic       ldReq = 1'b0;
  logic       useFast = 1'b0;

  logic       mReady, mBusy, mDone, mCsn, mWrn, mLdacn, mAB;
  logic [7:0] mD;
  logic       fReady, fBusy, fDone, fCsn, fWrn, fLdacn, fAB;
  logic [7:0] fD;

  logic       oReady, oBusy, oDone, oCsn, oWrn, oLdacn, oAB;
  logic [7:0] oD;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic       sel;
    logic       load;
  } exp_t;
  exp_t expQ[$];
  logic ldSeen = 1'b0;
  logic [7:0] lastCode [2];
  logic       lastSel  [2];

  always #5 clk = ~clk;

  dac_write_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid & ~useFast), .in_ready(mReady),
    .in_code(inCode), .in_sel(inSel), .in_defer(inDefer),
    .ld_req(ldReq & ~useFast),
    .busy(mBusy), .done(mDone),
    .dac_csn(mCsn), .dac_wrn(mWrn), .dac_ldacn(mLdacn),
    .dac_a_b(mAB), .dac_d(mD)
  );

  dac_write_seq #(.SETUP_CYC(1), .WR_CYC(1), .HOLD_CYC(1), .LDAC_CYC(1)) dutFast (
    .clk(clk), .rst(rst),
    .in_valid(inValid & useFast), .in_ready(fReady),
    .in_code(inCode), .in_sel(inSel), .in_defer(inDefer),
    .ld_req(ldReq & useFast),
    .busy(fBusy), .done(fDone),
    .dac_csn(fCsn), .dac_wrn(fWrn), .dac_ldacn(fLdacn),
    .dac_a_b(fAB), .dac_d(fD)
  );

  always_comb begin
    if (useFast) {oReady, oBusy, oDone, oCsn, oWrn, oLdacn, oAB, oD} = {fReady, fBusy, fDone, fCsn, fWrn, fLdacn, fAB, fD};
    else         {oReady, oBusy, oDone, oCsn, oWrn, oLdacn, oAB, oD} = {mReady, mBusy, mDone, mCsn, mWrn, mLdacn, mAB, mD};
  end

  // Scoreboard: every done pulse must match the oldest queued write or load.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expQ.delete();
      ldSeen = 1'b0;
    end else begin
      if (!oLdacn) ldSeen = 1'b1;
      if (oDone) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected_done: got done=1 required no pending sequence");
        end else begin
          e = expQ.pop_front();
          if ({oD, oAB, ldSeen} !== {e.code, e.sel, e.load}) begin
            errors++;
            $display("[TB] FAIL sb_done: got d=%h ab=%b load=%b required d=%h ab=%b load=%b",
                     oD, oAB, ldSeen, e.code, e.sel, e.load);
          end
        end
        ldSeen = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({oCsn, oWrn, oLdacn, oDone, oBusy, oReady, oAB, oD} !== {6'b111001, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b_%b_%h required 111001_0_00",
               {oCsn, oWrn, oLdacn, oDone, oBusy, oReady}, oAB, oD);
    end
    lastCode[0] = 8'h00; lastCode[1] = 8'h00;
    lastSel[0]  = 1'b0;  lastSel[1]  = 1'b0;
  endtask

  // Runs one write from IDLE and checks every cycle against the phase-width model.
  task automatic run_write(input logic [7:0] code, input logic sel, input logic defer,
                           input logic ld, input int ldPulse, input string name);
    int s, w, h, l, total, fi;
    logic loadRuns;
    logic [5:0] expV, gotV;
    exp_t e;
    fi = useFast ? 1 : 0;
    s = useFast ? 1 : SETUP_CYC_DEF;
    w = useFast ? 1 : WR_CYC_DEF;
    h = useFast ? 1 : HOLD_CYC_DEF;
    l = useFast ? 1 : LDAC_CYC_DEF;
    loadRuns = ~defer | ld;
    total = s + w + h + (loadRuns ? l : 0) + 1;
    inValid = 1'b1; inCode = code; inSel = sel; inDefer = defer; ldReq = ld;
    e.code = code; e.sel = sel; e.load = loadRuns;
    expQ.push_back(e);
    lastCode[fi] = code; lastSel[fi] = sel;
    tick();
    inValid = 1'b0; ldReq = 1'b0; inDefer = 1'b0;
    for (int k = 1; k <= total; k++) begin
      expV[5] = ~(k <= s + w + h);
      expV[4] = ~(k > s && k <= s + w);
      expV[3] = ~(loadRuns && k > s + w + h && k <= s + w + h + l);
      expV[2] = (k == total);
      expV[1] = (k < total);
      expV[0] = (k == total);
      gotV = {oCsn, oWrn, oLdacn, oDone, oBusy, oReady};
      checks++;
      if (gotV !== expV || oD !== code || oAB !== sel) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got strb=%b d=%h ab=%b required strb=%b d=%h ab=%b",
                 name, k, gotV, oD, oAB, expV, code, sel);
      end
      if (k < total) begin
        if (k == ldPulse) ldReq = 1'b1;
        tick();
        ldReq = 1'b0;
      end
    end
  endtask

  task automatic run_load_only(input string name);
    int l, fi;
    logic [5:0] expV, gotV;
    exp_t e;
    fi = useFast ? 1 : 0;
    l = useFast ? 1 : LDAC_CYC_DEF;
    ldReq = 1'b1;
    e.code = lastCode[fi]; e.sel = lastSel[fi]; e.load = 1'b1;
    expQ.push_back(e);
    tick();
    ldReq = 1'b0;
    for (int k = 1; k <= l + 1; k++) begin
      expV = {1'b1, 1'b1, ~(k <= l), (k == l + 1), (k <= l), (k == l + 1)};
      gotV = {oCsn, oWrn, oLdacn, oDone, oBusy, oReady};
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got strb=%b required strb=%b", name, k, gotV, expV);
      end
      if (k <= l) tick();
    end
  endtask

  task automatic test_default_write();
    run_write(8'h5A, 1'b0, 1'b0, 1'b0, 0, "default_write");
  endtask

  task automatic test_defer_and_load();
    run_write(8'hC3, 1'b1, 1'b1, 1'b0, 0, "deferred_write");
    run_load_only("load_only");
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e;
    inValid = 1'b1; inCode = 8'h01; inSel = 1'b0; inDefer = 1'b0;
    e.code = 8'h01; e.sel = 1'b0; e.load = 1'b1;
    expQ.push_back(e);
    tick();
    inCode = 8'h02;
    e.code = 8'h02;
    expQ.push_back(e);
    n = 1;
    while (!oReady && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("[TB] FAIL b2b_period: got ready at cycle %0d required 10", n);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if ({oBusy, oReady, oD} !== {1'b1, 1'b0, 8'h02}) begin
      errors++;
      $display("[TB] FAIL b2b_second_accept: got busy=%b ready=%b d=%h required 1 0 02", oBusy, oReady, oD);
    end
    n = 0;
    while (!oReady && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("[TB] FAIL b2b_second_done: got idle after %0d cycles required 9", n);
    end
    lastCode[0] = 8'h02; lastSel[0] = 1'b0;
  endtask

  task automatic test_ld_interactions();
    run_write(8'h3C, 1'b0, 1'b1, 1'b1, 0, "valid_with_ld");
    run_write(8'h96, 1'b1, 1'b1, 1'b0, 4, "ld_during_write");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    inValid = 1'b1; inCode = 8'h77; inSel = 1'b1; inDefer = 1'b0;
    e.code = 8'h77; e.sel = 1'b1; e.load = 1'b1;
    expQ.push_back(e);
    tick();
    inValid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({oCsn, oWrn} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_write_phase: got csn=%b wrn=%b required 0 0", oCsn, oWrn);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({oCsn, oWrn, oLdacn, oDone, oBusy, oAB, oD} !== {5'b11100, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_mid_write: got %b_%b_%h required 11100_0_00",
               {oCsn, oWrn, oLdacn, oDone, oBusy}, oAB, oD);
    end
    tick();
    checks++;
    if ({oDone, oReady} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got done=%b ready=%b required 0 1", oDone, oReady);
    end
    lastCode[0] = 8'h00; lastCode[1] = 8'h00;
    lastSel[0]  = 1'b0;  lastSel[1]  = 1'b0;
    run_write(8'hE1, 1'b0, 1'b0, 1'b0, 0, "after_reset_write");
  endtask

  task automatic test_min_widths();
    useFast = 1'b1;
    tick();
    run_write(8'hA5, 1'b1, 1'b0, 1'b0, 0, "fast_write");
    run_write(8'h5B, 1'b0, 1'b1, 1'b0, 0, "fast_deferred");
    run_load_only("fast_load_only");
    tick();
    useFast = 1'b0;
    tick();
  endtask

  initial begin
    $display("[TB] dac_write_seq bench start");
    test_reset();
    test_default_write();
    tick();
    test_defer_and_load();
    tick();
    test_back_to_back();
    tick();
    test_ld_interactions();
    tick();
    test_reset_mid();
    tick();
    test_min_widths();
    tick();
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
